// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions used by the RX and TX paths.
//   - flow_state_t : receive flow-control state (send allowed / throttled)
//   - RX_ERR_W     : width of the receiver error flag vector
//   - rx_err_t     : named view of the receiver error flags
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic {
        FLOW_OPEN     = 1'b0,
        FLOW_THROTTLE = 1'b1
    } flow_state_t;

    localparam int RX_ERR_W = 3;

    // Bit positions inside the receiver error vector.
    localparam int ERR_BIT_FRAMING = 0;
    localparam int ERR_BIT_PARITY  = 1;
    localparam int ERR_BIT_BREAK   = 2;

    typedef struct packed {
        logic brk;      // break condition detected
        logic parity;   // parity mismatch
        logic framing;  // missing stop bit
    } rx_err_t;

    // True when any error flag is raised: the byte must be discarded.
    function automatic logic rx_err_any(input rx_err_t e);
        return e.framing | e.parity | e.brk;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock register-array FIFO with show-ahead head output.
//   A push into a full FIFO is accepted only when a pop happens in the same
//   cycle; a pop from an empty FIFO is ignored. Storage is not reset, only
//   the pointers and the occupancy count.
// Ports
//   i_clk    in   clock, posedge
//   i_rst_n  in   synchronous reset, active-low
//   i_push   in   write i_data at the tail
//   i_data   in   DATA_BITS write data
//   i_pop    in   remove the head entry
//   o_full   out  count == FIFO_DEPTH
//   o_empty  out  count == 0
//   o_count  out  occupancy, one bit wider than the pointers
//   o_head   out  entry at the read pointer
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_pop,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic [DATA_BITS-1:0]          o_head
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_flow_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_flow_ctrl
//   UART receive sequencer: captures completed bytes from the receiver into
//   a local FIFO, presents them over valid/ready, drives RTS from FIFO fill
//   with hysteresis and keeps overrun / error statistics.
// Ports
//   Clk             in   clock, posedge
//   Rst_n           in   synchronous reset, active-low
//   Rx_Data_In      in   received byte, stable while Rx_Data_Rdy_In is high
//   Rx_Data_Rdy_In  in   byte-ready strobe; only its rising edge captures
//   Rx_Error_In     in   error flags sampled with the strobe, nonzero = bad
//   Rx_Rts_In       in   receiver's own ready-to-send, gates RTS
//   RTS             out  1 = remote transmitter may send
//   Rd_Data_Out     out  FIFO head, 0 when empty
//   Rd_Valid_Out    out  head valid
//   Rd_Ready_In     in   consumer takes the head
//   Fill_Out        out  FIFO occupancy
//   Overrun_Out     out  sticky, a good byte was dropped on a full FIFO
//   Err_Count_Out   out  saturating count of discarded errored bytes
//   Clear_Stat_In   in   clears Overrun_Out and Err_Count_Out
// ---------------------------------------------------------------------------
module uart_rx_flow_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int RTS_HIGH_WM = 12,
    parameter int RTS_LOW_WM  = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic [DATA_BITS-1:0]          Rx_Data_In,
    input  logic                          Rx_Data_Rdy_In,
    input  logic [RX_ERR_W-1:0]           Rx_Error_In,
    input  logic                          Rx_Rts_In,
    output logic                          RTS,
    output logic [DATA_BITS-1:0]          Rd_Data_Out,
    output logic                          Rd_Valid_Out,
    input  logic                          Rd_Ready_In,
    output logic [$clog2(FIFO_DEPTH):0]   Fill_Out,
    output logic                          Overrun_Out,
    output logic [ERR_CNT_W-1:0]          Err_Count_Out,
    input  logic                          Clear_Stat_In
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Hysteresis: withdraw at the high mark, re-open only at the low mark.
    function automatic flow_state_t flow_next(input flow_state_t s,
                                              input logic [CNT_W-1:0] cnt);
        flow_state_t n;
        n = s;
        case (s)
            FLOW_OPEN:     if (cnt >= CNT_W'(RTS_HIGH_WM)) n = FLOW_THROTTLE;
            FLOW_THROTTLE: if (cnt <= CNT_W'(RTS_LOW_WM))  n = FLOW_OPEN;
            default:       n = FLOW_OPEN;
        endcase
        return n;
    endfunction

    logic                  r_rdy_prev;
    flow_state_t           r_flow_state;
    logic                  r_rts;
    logic                  r_overrun;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    logic                  w_strobe;
    logic                  w_bad;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_err_ev;
    logic                  w_overrun_ev;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [DATA_BITS-1:0]  w_head;
    flow_state_t           w_flow_next;

    // Stage 0: strobe edge detection and capture qualification.
    // A strobe held high for several cycles produces a single capture.
    assign w_strobe     = Rx_Data_Rdy_In && !r_rdy_prev;
    assign w_bad        = rx_err_any(rx_err_t'(Rx_Error_In));
    assign w_push       = w_strobe && !w_bad;
    assign w_err_ev     = w_strobe && w_bad;
    assign w_pop        = !w_empty && Rd_Ready_In;
    assign w_overrun_ev = w_push && w_full && !w_pop;

    always_ff @(posedge Clk) begin
        if (!Rst_n) r_rdy_prev <= 1'b0;
        else        r_rdy_prev <= Rx_Data_Rdy_In;
    end

    uart_sync_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_push  (w_push),
        .i_data  (Rx_Data_In),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Stage 1: flow FSM on the registered count; RTS is registered from the
    // next state, so it drops one edge after the push reaching the high mark.
    assign w_flow_next = flow_next(r_flow_state, w_count);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_flow_state <= FLOW_OPEN;
            r_rts        <= 1'b0;
        end else begin
            r_flow_state <= w_flow_next;
            r_rts        <= (w_flow_next == FLOW_OPEN) && Rx_Rts_In;
        end
    end

    // Statistics: a new event in the same cycle as a clear takes priority.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_overrun_ev)       r_overrun <= 1'b1;
            else if (Clear_Stat_In) r_overrun <= 1'b0;

            if (Clear_Stat_In)      r_err_cnt <= w_err_ev ? ERR_CNT_W'(1) : '0;
            else if (w_err_ev)      r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign RTS           = r_rts;
    assign Rd_Valid_Out  = !w_empty;
    assign Rd_Data_Out   = w_empty ? '0 : w_head;
    assign Fill_Out      = w_count;
    assign Overrun_Out   = r_overrun;
    assign Err_Count_Out = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_flow_ctrl.sv
module tb_uart_rx_flow_ctrl;

    localparam int DEPTH = 16;
    localparam int HI_WM = 12;
    localparam int LO_WM = 4;
    localparam int ERR_MAX = 255;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [7:0] Rx_Data_In = '0;
    logic       Rx_Data_Rdy_In = 1'b0;
    logic [2:0] Rx_Error_In = '0;
    logic       Rx_Rts_In = 1'b1;
    logic       RTS;
    logic [7:0] Rd_Data_Out;
    logic       Rd_Valid_Out;
    logic       Rd_Ready_In = 1'b0;
    logic [4:0] Fill_Out;
    logic       Overrun_Out;
    logic [7:0] Err_Count_Out;
    logic       Clear_Stat_In = 1'b0;

    uart_rx_flow_ctrl dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Rx_Data_In     (Rx_Data_In),
        .Rx_Data_Rdy_In (Rx_Data_Rdy_In),
        .Rx_Error_In    (Rx_Error_In),
        .Rx_Rts_In      (Rx_Rts_In),
        .RTS            (RTS),
        .Rd_Data_Out    (Rd_Data_Out),
        .Rd_Valid_Out   (Rd_Valid_Out),
        .Rd_Ready_In    (Rd_Ready_In),
        .Fill_Out       (Fill_Out),
        .Overrun_Out    (Overrun_Out),
        .Err_Count_Out  (Err_Count_Out),
        .Clear_Stat_In  (Clear_Stat_In)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of bytes plus the visible status values.
    byte unsigned m_q[$];
    int           m_err = 0;
    bit           m_ov = 0;
    bit           m_throttled = 0;
    bit           m_rts = 0;
    bit           m_prev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs as currently driven.
    task automatic model_step();
        int  fill;
        bit  rise, bad, pop, ovev, errev;
        if (!Rst_n) begin
            m_q.delete();
            m_err = 0; m_ov = 0; m_throttled = 0; m_rts = 0; m_prev = 0;
            return;
        end
        fill  = m_q.size();
        rise  = Rx_Data_Rdy_In && !m_prev;
        bad   = (Rx_Error_In != 0);
        pop   = (fill > 0) && Rd_Ready_In;
        ovev  = 0;
        errev = rise && bad;
        if (!m_throttled && fill >= HI_WM)      m_throttled = 1;
        else if (m_throttled && fill <= LO_WM)  m_throttled = 0;
        m_rts = !m_throttled && Rx_Rts_In;
        if (pop) void'(m_q.pop_front());
        if (rise && !bad) begin
            if (fill < DEPTH || pop) m_q.push_back(Rx_Data_In);
            else                     ovev = 1;
        end
        if (Clear_Stat_In)            m_err = errev ? 1 : 0;
        else if (errev && m_err < ERR_MAX) m_err++;
        if (ovev)               m_ov = 1;
        else if (Clear_Stat_In) m_ov = 0;
        m_prev = Rx_Data_Rdy_In;
    endtask

    task automatic check_all();
        chk("fill",  Fill_Out, m_q.size());
        chk("valid", Rd_Valid_Out, (m_q.size() != 0));
        chk("data",  Rd_Data_Out, (m_q.size() != 0) ? m_q[0] : 0);
        chk("rts",   RTS, m_rts);
        chk("ovr",   Overrun_Out, m_ov);
        chk("err",   Err_Count_Out, m_err);
    endtask

    task automatic cyc();
        model_step();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic push_byte(input logic [7:0] b, input logic [2:0] e);
        Rx_Data_In = b; Rx_Error_In = e; Rx_Data_Rdy_In = 1'b1;
        cyc();
        Rx_Data_Rdy_In = 1'b0; Rx_Error_In = '0;
        cyc();
    endtask

    initial begin
        // 1: reset
        Rst_n = 1'b0; Rx_Rts_In = 1'b1;
        repeat (4) cyc();
        chk("t1_rts", RTS, 0);
        chk("t1_fill", Fill_Out, 0);
        chk("t1_valid", Rd_Valid_Out, 0);
        chk("t1_err", Err_Count_Out, 0);
        Rst_n = 1'b1;
        cyc();
        chk("t1_rts_rel", RTS, 1);

        // 2: single byte, show-ahead, then pop
        Rx_Data_In = 8'hA5; Rx_Data_Rdy_In = 1'b1;
        cyc();
        chk("t2_valid", Rd_Valid_Out, 1);
        chk("t2_data", Rd_Data_Out, 8'hA5);
        chk("t2_fill", Fill_Out, 1);
        Rx_Data_Rdy_In = 1'b0;
        cyc();
        Rd_Ready_In = 1'b1;
        cyc();
        Rd_Ready_In = 1'b0;
        chk("t2_fill0", Fill_Out, 0);
        chk("t2_valid0", Rd_Valid_Out, 0);

        // 3: RTS hysteresis
        for (int i = 0; i < 12; i++) push_byte(8'(i), 3'b000);
        chk("t3_rts_hi", RTS, 0);
        chk("t3_fill12", Fill_Out, 12);
        Rd_Ready_In = 1'b1;
        repeat (7) cyc();
        Rd_Ready_In = 1'b0;
        cyc();
        chk("t3_fill5", Fill_Out, 5);
        chk("t3_rts5", RTS, 0);
        Rd_Ready_In = 1'b1;
        cyc();
        Rd_Ready_In = 1'b0;
        cyc();
        chk("t3_fill4", Fill_Out, 4);
        chk("t3_rts4", RTS, 1);

        // 4: overrun and ordered drain
        Rd_Ready_In = 1'b1;
        repeat (4) cyc();
        Rd_Ready_In = 1'b0;
        for (int i = 0; i < 17; i++) push_byte(8'(i), 3'b000);
        chk("t4_fill16", Fill_Out, 16);
        chk("t4_ovr", Overrun_Out, 1);
        for (int i = 0; i < 16; i++) begin
            chk("t4_order", Rd_Data_Out, i);
            Rd_Ready_In = 1'b1;
            cyc();
        end
        Rd_Ready_In = 1'b0;
        chk("t4_empty", Fill_Out, 0);
        Clear_Stat_In = 1'b1;
        cyc();
        Clear_Stat_In = 1'b0;
        chk("t4_ovr_clr", Overrun_Out, 0);

        // 5: errored bytes, saturation, held strobe
        push_byte(8'h3C, 3'b010);
        chk("t5_fill", Fill_Out, 0);
        chk("t5_err1", Err_Count_Out, 1);
        for (int i = 0; i < 300; i++) push_byte(8'(i), 3'(1 + (i % 7)));
        chk("t5_err_sat", Err_Count_Out, 255);
        Rx_Data_In = 8'h5A; Rx_Data_Rdy_In = 1'b1;
        repeat (3) cyc();
        Rx_Data_Rdy_In = 1'b0;
        cyc();
        chk("t5_held_one", Fill_Out, 1);

        // 6: full + simultaneous push/pop, then mid-stream reset
        Clear_Stat_In = 1'b1;
        cyc();
        Clear_Stat_In = 1'b0;
        chk("t6_err_clr", Err_Count_Out, 0);
        for (int i = 0; i < 15; i++) push_byte(8'(8'h60 + i), 3'b000);
        chk("t6_full", Fill_Out, 16);
        Rx_Data_In = 8'hEE; Rx_Data_Rdy_In = 1'b1; Rd_Ready_In = 1'b1;
        cyc();
        Rx_Data_Rdy_In = 1'b0; Rd_Ready_In = 1'b0;
        chk("t6_fill_same", Fill_Out, 16);
        chk("t6_no_ovr", Overrun_Out, 0);
        Rd_Ready_In = 1'b1;
        repeat (15) cyc();
        Rd_Ready_In = 1'b0;
        chk("t6_tail", Rd_Data_Out, 8'hEE);
        Rx_Data_In = 8'h77; Rx_Data_Rdy_In = 1'b1; Rst_n = 1'b0;
        repeat (2) cyc();
        chk("t6_rst_fill", Fill_Out, 0);
        chk("t6_rst_valid", Rd_Valid_Out, 0);
        chk("t6_rst_data", Rd_Data_Out, 0);
        chk("t6_rst_rts", RTS, 0);
        Rx_Data_Rdy_In = 1'b0; Rst_n = 1'b1;
        cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            Rx_Data_Rdy_In = 1'($urandom_range(0, 1));
            Rx_Data_In     = 8'($urandom);
            Rx_Error_In    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            Rd_Ready_In    = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            Clear_Stat_In  = ($urandom_range(0, 49) == 0);
            Rx_Rts_In      = ($urandom_range(0, 9) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
